voice_sequencer: RTL
====================

# voice_sequencer

Pattern step sequencer that drives the note-control inputs of one synth voice, the upstream initiator of the voice's tone_freq/gate interface. A small register-file pattern of up to STEPS steps is written by the host. While running, the block plays the steps in order at a programmable step period. For each note step it presents the step's frequency word and a gate pulse of programmable length, with gate-low time guaranteed before the next step so the envelope always retriggers.

## Interface

- STEPS, default 16: pattern depth; must be a power of two ≥ 2.
- FREQ_BITS, default 16: width of the frequency word; matches the voice's tone_freq.
- TICK_BITS, default 24: width of the step-period and gate-length counters.

- clk, input, 1: system clock; all logic on the rising edge.
- rst, input, 1: asynchronous, active-low reset.
- run, input, 1: level. High means play; low means stop and rewind.
- loop, input, 1: 1 means wrap to step 0 after the last step; 0 means stop after the last step.
- num_steps, input, $clog2(STEPS)+1: active pattern length. Values 0 and >STEPS are treated as STEPS.
- step_period, input, TICK_BITS: clocks per step. Values <2 are treated as 2.
- gate_len, input, TICK_BITS: clocks the gate is high per note step.
- wr_en, input, 1: pattern write strobe, one entry per cycle, always accepted.
- wr_addr, input, $clog2(STEPS): pattern entry index.
- wr_data, input, FREQ_BITS+1: {rest, freq}. rest=1 marks a silent step.
- tone_freq, output, FREQ_BITS: frequency word to the voice.
- gate, output, 1: envelope gate to the voice.
- step_index, output, $clog2(STEPS): index of the step currently playing.
- step_strobe, output, 1: one-cycle pulse on the first cycle of every step.
- busy, output, 1: high whenever the state is not IDLE.

## Operation

- States: IDLE, GATE_ON, GATE_OFF. A TICK_BITS counter `cnt` counts clocks within a step.
- Effective gate length: g = min(gate_len, P−1), where P is the effective step period. gate_len=0 makes the step behave as a rest.
- Step entry, from IDLE with run=1, or at the end of a step:
  - cnt←0, step_strobe←1.
  - If the entry is not rest, tone_freq←freq.
  - If the entry is not rest and g≠0: gate←1 and next state is GATE_ON. Otherwise gate←0 and next state is GATE_OFF.
  - On a rest step, tone_freq holds its previous value.
- GATE_ON: cnt increments each cycle. When cnt==g−1: gate←0 and go to GATE_OFF.
- GATE_OFF: cnt increments each cycle. When cnt==P−1, the step ends:
  - next = step_index+1, wrapping to 0 at num_steps.
  - If the index wraps and loop=0: go to IDLE with step_index←0.
  - Otherwise enter step `next`.
- run=0 in any state: next cycle state=IDLE, gate=0, cnt=0, step_index=0. tone_freq holds.
- run held high after a loop=0 completion does not restart playback. A new 0→1 edge of run is required; the block keeps a registered copy of run for edge detection.
- Pattern write and step entry read the same address in the same cycle: the step plays the old contents. The write lands for the next visit.
- num_steps, step_period and gate_len are sampled continuously. A change mid-step takes effect on the next comparison. If cnt is already past a new limit, the comparison fires when cnt wraps; this is legal but not required to be musical.

## Timing

- Reset values: tone_freq=0, gate=0, step_index=0, step_strobe=0, busy=0, state=IDLE, cnt=0. Pattern contents are not reset.
- Start latency: run rises and is sampled at edge N. At edge N+1, step_strobe=1, gate=1 (note step), tone_freq is valid and busy=1.
- Each step lasts exactly P cycles. Gate is high for exactly g cycles starting at step entry. Gate is low for at least 1 cycle before the next step_strobe.
- step_strobe is high only on entry cycles. tone_freq and gate change on the same edge as step_strobe.
- Stop latency: run falls and is sampled at edge N. At edge N+1, gate=0 and busy=0.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure

- Shared package voice_seq_pkg:
  - state enum {IDLE, GATE_ON, GATE_OFF}.
  - step record typedef {rest, freq[FREQ_BITS]}.
  - helper function for clamping num_steps and step_period.
- One sub-module, voice_seq_pattern_ram: STEPS×(FREQ_BITS+1) register file with one synchronous write port and one combinational read port. It has no reset.
- Top level contains the FSM, cnt, step_index and the run edge detector.

## Test plan

- Reset, then write a 4-step pattern {0x1000, 0x2000, rest, 0x4000} with num_steps=4, step_period=10, gate_len=6, loop=1, run=1.
  - Required: strobes every 10 cycles; gate high for 6 cycles on steps 0, 1 and 3.
  - tone_freq sequence is 0x1000, 0x2000, 0x2000 (held through the rest), 0x4000, then wraps back to 0x1000.
- Set gate_len=50 with step_period=10. Required: gate high for 9 cycles, low for 1 cycle, every step.
- loop=0 with num_steps=2. Required: exactly 2 strobes, then busy=0 and step_index=0. With run held high there is no restart; a run 0→1 edge restarts playback.
- Drop run mid-GATE_ON. Required: the next edge gives gate=0, busy=0, step_index=0, and tone_freq unchanged.
- Write entry 1 on the exact cycle step 1 is entered. Required: the old value plays now and the new value plays on the next loop.
- step_period=0 and num_steps=0. Required: the block behaves as period 2 over STEPS steps. Assert rst low mid-step: all outputs take their reset values immediately, without waiting for a clock.

Source files
------------

// File: rtl/voice_seq_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : voice_seq_pkg
//  Purpose  : Shared types and helpers for the voice step sequencer.
//             - seq_state_t : sequencer FSM state encoding
//             - step_t      : pattern entry record {rest, freq}, laid out at the
//                             default frequency width; modules built with a
//                             different width declare the same layout locally
//             - clamp_num_steps / clamp_period : legalise host settings
//  Revision : 1.0  initial release
// ============================================================================
package voice_seq_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GATE_ON  = 2'd1,
        GATE_OFF = 2'd2
    } seq_state_t;

    localparam int unsigned c_DEFAULT_FREQ_BITS = 16;
    localparam logic [31:0] c_MIN_PERIOD        = 32'd2;

    typedef struct packed {
        logic                           rest;
        logic [c_DEFAULT_FREQ_BITS-1:0] freq;
    } step_t;

    // Zero or anything beyond the pattern depth means "use the whole pattern".
    function automatic logic [31:0] clamp_num_steps(input logic [31:0] n,
                                                    input logic [31:0] steps);
        return ((n == 32'd0) || (n > steps)) ? steps : n;
    endfunction

    // A step needs at least one gate-high and one gate-low cycle.
    function automatic logic [31:0] clamp_period(input logic [31:0] p);
        return (p < c_MIN_PERIOD) ? c_MIN_PERIOD : p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/voice_seq_pattern_ram.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : voice_seq_pattern_ram
//  Purpose  : STEPS x WIDTH pattern register file. One synchronous write port,
//             one combinational read port. Contents are not reset.
//  Ports    : clk        - system clock
//             i_wr_en    - write strobe
//             i_wr_addr  - write index
//             i_wr_data  - write data {rest, freq}
//             i_rd_addr  - read index
//             o_rd_data  - read data (current contents, pre-write on a
//                          same-cycle write to the same address)
//  Revision : 1.0  initial release
// ============================================================================
module voice_seq_pattern_ram
    import voice_seq_pkg::*;
#(
    parameter int STEPS = 16,
    parameter int WIDTH = 17
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(STEPS)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic [$clog2(STEPS)-1:0] i_rd_addr,
    output logic [WIDTH-1:0]         o_rd_data
);

    logic [WIDTH-1:0] r_mem [STEPS];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/voice_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : voice_sequencer
//  Purpose  : Pattern step sequencer driving one synth voice (tone_freq/gate).
//             Plays up to STEPS host-written steps at a programmable period,
//             with a programmable gate length and guaranteed gate-low time
//             before every step so the envelope always retriggers.
//  Ports    : clk, rst (async, active low)
//             run, loop               - play/stop level, wrap enable
//             num_steps, step_period, gate_len - timing/length settings
//             wr_en, wr_addr, wr_data - pattern write port {rest, freq}
//             tone_freq, gate         - voice note controls (registered)
//             step_index, step_strobe, busy - playback status (registered)
//  Revision : 1.0  initial release
// ============================================================================
module voice_sequencer
    import voice_seq_pkg::*;
#(
    parameter int STEPS     = 16,
    parameter int FREQ_BITS = 16,
    parameter int TICK_BITS = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic                     loop,
    input  logic [$clog2(STEPS):0]   num_steps,
    input  logic [TICK_BITS-1:0]     step_period,
    input  logic [TICK_BITS-1:0]     gate_len,
    input  logic                     wr_en,
    input  logic [$clog2(STEPS)-1:0] wr_addr,
    input  logic [FREQ_BITS:0]       wr_data,
    output logic [FREQ_BITS-1:0]     tone_freq,
    output logic                     gate,
    output logic [$clog2(STEPS)-1:0] step_index,
    output logic                     step_strobe,
    output logic                     busy
);

    localparam int c_IDX_W = $clog2(STEPS);

    typedef struct packed {
        logic                 rest;
        logic [FREQ_BITS-1:0] freq;
    } step_rec_t;

    // ------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------
    seq_state_t           r_state, w_state_next;
    logic [TICK_BITS-1:0] r_cnt, w_cnt_next;
    logic [c_IDX_W-1:0]   r_step_index, w_step_index_next;
    logic [FREQ_BITS-1:0] r_tone_freq, w_tone_freq_next;
    logic                 r_gate, w_gate_next;
    logic                 r_step_strobe, w_step_strobe_next;
    logic                 r_run_q;

    // ------------------------------------------------------------------
    // Effective settings
    // ------------------------------------------------------------------
    logic [c_IDX_W:0]     w_num_eff;
    logic [TICK_BITS-1:0] w_period;
    logic [TICK_BITS-1:0] w_gate_eff;
    logic [TICK_BITS-1:0] w_last_tick;
    logic [TICK_BITS-1:0] w_gate_last;

    assign w_num_eff   = (c_IDX_W+1)'(clamp_num_steps(32'(num_steps), 32'(STEPS)));
    assign w_period    = TICK_BITS'(clamp_period(32'(step_period)));
    // Capping at P-1 leaves at least one gate-low cycle in every step.
    assign w_gate_eff  = (gate_len < w_period) ? gate_len : (w_period - TICK_BITS'(1));
    assign w_last_tick = w_period - TICK_BITS'(1);
    // g=0 never reaches GATE_ON, so the wrap of g-1 is harmless.
    assign w_gate_last = w_gate_eff - TICK_BITS'(1);

    // ------------------------------------------------------------------
    // Step advance and pattern read
    // ------------------------------------------------------------------
    logic [c_IDX_W:0]   w_next_wide;
    logic               w_wrap;
    logic [c_IDX_W-1:0] w_entry_addr;
    logic [FREQ_BITS:0] w_rd_data;
    step_rec_t          w_entry;
    logic               w_run_rise;

    assign w_next_wide = {1'b0, r_step_index} + (c_IDX_W+1)'(1);
    // ">=" rather than "==" so a num_steps shrunk below the current index
    // still wraps instead of running off to the full depth.
    assign w_wrap      = (w_next_wide >= w_num_eff);
    assign w_entry_addr = ((r_state == IDLE) || w_wrap) ? '0 : w_next_wide[c_IDX_W-1:0];
    assign w_entry     = step_rec_t'(w_rd_data);
    // Playback only starts on a fresh rising edge of run, so a run level
    // held high after a one-shot completion does not replay the pattern.
    assign w_run_rise  = run & ~r_run_q;

    voice_seq_pattern_ram #(
        .STEPS (STEPS),
        .WIDTH (FREQ_BITS + 1)
    ) u_pattern_ram (
        .clk       (clk),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_addr (w_entry_addr),
        .o_rd_data (w_rd_data)
    );

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    logic w_enter;

    always_comb begin
        w_state_next       = r_state;
        w_cnt_next         = r_cnt + TICK_BITS'(1);
        w_step_index_next  = r_step_index;
        w_tone_freq_next   = r_tone_freq;
        w_gate_next        = r_gate;
        w_step_strobe_next = 1'b0;
        w_enter            = 1'b0;

        if (!run) begin
            w_state_next      = IDLE;
            w_cnt_next        = '0;
            w_step_index_next = '0;
            w_gate_next       = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_cnt_next = '0;
                    if (w_run_rise) begin
                        w_enter = 1'b1;
                    end
                end
                GATE_ON: begin
                    if (r_cnt == w_gate_last) begin
                        w_gate_next  = 1'b0;
                        w_state_next = GATE_OFF;
                    end
                end
                GATE_OFF: begin
                    if (r_cnt == w_last_tick) begin
                        if (w_wrap && !loop) begin
                            w_state_next      = IDLE;
                            w_cnt_next        = '0;
                            w_step_index_next = '0;
                        end else begin
                            w_enter = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_next      = IDLE;
                    w_cnt_next        = '0;
                    w_step_index_next = '0;
                    w_gate_next       = 1'b0;
                end
            endcase

            if (w_enter) begin
                w_cnt_next         = '0;
                w_step_strobe_next = 1'b1;
                w_step_index_next  = w_entry_addr;
                // A rest keeps the previous pitch so the voice does not glitch.
                if (!w_entry.rest) begin
                    w_tone_freq_next = w_entry.freq;
                end
                if (!w_entry.rest && (w_gate_eff != '0)) begin
                    w_gate_next  = 1'b1;
                    w_state_next = GATE_ON;
                end else begin
                    w_gate_next  = 1'b0;
                    w_state_next = GATE_OFF;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_step_index  <= '0;
            r_tone_freq   <= '0;
            r_gate        <= 1'b0;
            r_step_strobe <= 1'b0;
            r_run_q       <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_step_index  <= w_step_index_next;
            r_tone_freq   <= w_tone_freq_next;
            r_gate        <= w_gate_next;
            r_step_strobe <= w_step_strobe_next;
            r_run_q       <= run;
        end
    end

    assign tone_freq   = r_tone_freq;
    assign gate        = r_gate;
    assign step_index  = r_step_index;
    assign step_strobe = r_step_strobe;
    assign busy        = (r_state != IDLE);

endmodule
`default_nettype wire
